// File: rtl/mano_main_mem.sv
// mano_main_mem: fixed-latency 2^ADDR_W x DATA_W main memory behind a ready/ack handshake
module mano_main_mem #(
  parameter int    ADDR_W    = 12,
  parameter int    DATA_W    = 16,
  parameter int    RD_LAT    = 3,
  parameter int    WR_LAT    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mem_rd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              rd_ack,
  output logic              wr_ack
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [1:0] state;
  logic [3:0] cnt;
  logic pend, acc, done;
  logic [ADDR_W-1:0] addr_q;
  assign acc  = mem_ready && state == IDLE && (mem_rd || mem_wr);
  assign done = cnt <= 4'd1;
  // Writes commit at acceptance, so a later (or pending) read always sees them
  always_ff @(posedge clk)
    if (acc && mem_wr) mem[mem_wr_addr] <= mem_wdata;
  // A refill arriving with a write-back waits behind it; it gets a full RD_LAT from the wr_ack edge
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pend      <= 1'b0;
      addr_q    <= '0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      rd_ack    <= 1'b0;
      wr_ack    <= 1'b0;
    end else begin
      rd_ack    <= 1'b0;
      wr_ack    <= 1'b0;
      mem_ready <= state == IDLE && !acc;
      case (state)
        IDLE: if (acc) begin
          state  <= mem_wr ? WR : RD;
          cnt    <= mem_wr ? 4'(WR_LAT - 1) : 4'(RD_LAT - 1);
          pend   <= mem_wr && mem_rd;
          addr_q <= mem_addr;
        end
        RD: begin
          cnt <= cnt - 4'd1;
          if (done) begin
            mem_rdata <= mem[addr_q];
            rd_ack    <= 1'b1;
            state     <= IDLE;
          end
        end
        WR: begin
          cnt <= cnt - 4'd1;
          if (done) begin
            wr_ack <= 1'b1;
            state  <= pend ? RD : IDLE;
            cnt    <= 4'(RD_LAT);
            pend   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
